// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tt_sweep_pkg
// Brief    : Shared defaults, sizes and state encoding for the truth-table
//            sweep/capture block.
// Revision : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    // Default FUT input count and the sizes derived from it
    localparam int N_IN_DEF  = 7;
    localparam int TT_W_DEF  = 2 ** N_IN_DEF;
    localparam int CNT_W_DEF = N_IN_DEF + 1;

    // Reference truth table of the majority network under characterisation
    localparam logic [TT_W_DEF-1:0] EXPECTED_DEF =
        128'hfeeaeaaaeee8e8a0fae8e888aaa8a880;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : tt_sweep_pkg
`default_nettype wire

// File: rtl/tt_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tt_lat_pipe
// Brief    : Valid-tag delay line that tracks the FUT latency so each sample
//            of f_i is captured against the minterm that produced it.
// Revision : 1.0 - initial release
// ============================================================================
module tt_lat_pipe #(
    parameter int DEPTH = 0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Combinational FUT: the tag is consumed in its issue cycle
            logic w_unused_ok;
            assign w_unused_ok = clk ^ rst_n;
            assign vld_o       = vld_i;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sr;

            // Shift the issue tag along DEPTH stages; reset empties the line
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= vld_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign vld_o = r_sr[DEPTH-1];
        end
    endgenerate

endmodule : tt_lat_pipe
`default_nettype wire

// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_capture
// Brief    : Drives every minterm of an N_IN-input Boolean function, captures
//            its output into a truth table, counts the onset and compares the
//            result against a reference signature.
// Revision : 1.0 - initial release
// ============================================================================
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int                     N_IN     = N_IN_DEF,
    parameter int                     DUT_LAT  = 0,
    parameter logic [(2**N_IN)-1:0]   EXPECTED = EXPECTED_DEF
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic [N_IN-1:0]           x_o,
    input  logic                      f_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [(2**N_IN)-1:0]      tt_o,
    output logic [N_IN:0]             ones_o,
    output logic                      match_o
);

    localparam int TT_W  = 2 ** N_IN;
    localparam int CNT_W = N_IN + 1;

    localparam logic [1:0]       c_st_idle  = IDLE;
    localparam logic [1:0]       c_st_sweep = SWEEP;
    localparam logic [1:0]       c_st_done  = DONE;

    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(TT_W - 1);
    // Issue counter parks one past the last minterm so "all issued" is a
    // plain compare; x_o saturates so the FUT keeps seeing TT_W-1.
    localparam logic [CNT_W-1:0] c_all_iss  = CNT_W'(TT_W);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_cap_cnt;
    logic [TT_W-1:0]  r_tt;
    logic [CNT_W-1:0] r_ones;
    logic             r_match;

    logic             w_start_acc;
    logic             w_issue_vld;
    logic             w_tag_tail;
    logic             w_cap_vld;
    logic             w_cap_last;

    assign w_start_acc = (r_state == c_st_idle) && start_i;
    assign w_issue_vld = (r_state == c_st_sweep) && (r_issue_cnt != c_all_iss);
    assign w_cap_vld   = (r_state == c_st_sweep) && w_tag_tail;
    assign w_cap_last  = w_cap_vld && (r_cap_cnt == c_last_idx);

    tt_lat_pipe #(
        .DEPTH (DUT_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (w_issue_vld),
        .vld_o (w_tag_tail)
    );

    // Sequencer: state transitions plus issue and capture counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_state     <= c_st_sweep;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                    end
                end
                c_st_sweep: begin
                    if (w_issue_vld) begin
                        r_issue_cnt <= r_issue_cnt + c_one;
                    end
                    if (w_cap_vld) begin
                        r_cap_cnt <= r_cap_cnt + c_one;
                    end
                    if (w_cap_last) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Result registers: cleared on accepted start, filled during capture,
    // held afterwards; the compare folds in the final bit being written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tt    <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
        end else if (w_start_acc) begin
            r_tt    <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
        end else if (w_cap_vld) begin
            r_tt[r_cap_cnt[N_IN-1:0]] <= f_i;
            r_ones                    <= r_ones + CNT_W'(f_i);
            if (w_cap_last) begin
                r_match <= ({f_i, r_tt[TT_W-2:0]} == EXPECTED);
            end
        end
    end

    assign x_o     = r_issue_cnt[N_IN] ? {N_IN{1'b1}} : r_issue_cnt[N_IN-1:0];
    assign busy_o  = (r_state == c_st_sweep);
    assign done_o  = (r_state == c_st_done);
    assign tt_o    = r_tt;
    assign ones_o  = r_ones;
    assign match_o = r_match;

endmodule : tt_sweep_capture
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_capture
// Brief    : Self-checking bench for tt_sweep_capture with a combinational FUT
//            (DUT_LAT=0) and a twice-registered FUT (DUT_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_capture;

    localparam logic [127:0] EXP = 128'hfeeaeaaaeee8e8a0fae8e888aaa8a880;

    logic         clk;
    logic         rst_n;
    logic         start0, start2;
    logic [6:0]   x0, x2;
    logic         f0, f2;
    logic         busy0, busy2, done0, done2, match0, match2;
    logic [127:0] tt0, tt2;
    logic [7:0]   ones0, ones2;
    logic [127:0] lut0, lut2;
    logic         p1, p2;

    int n_cmp;
    int n_bad;

    // Behavioural FUTs: a lookup table, combinational or delayed by two flops
    assign f0 = lut0[x0];
    always @(posedge clk) begin
        p1 <= lut2[x2];
        p2 <= p1;
    end
    assign f2 = p2;

    tt_sweep_capture #(.DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .x_o(x0), .f_i(f0),
        .busy_o(busy0), .done_o(done0), .tt_o(tt0), .ones_o(ones0), .match_o(match0)
    );

    tt_sweep_capture #(.DUT_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .x_o(x2), .f_i(f2),
        .busy_o(busy2), .done_o(done2), .tt_o(tt2), .ones_o(ones2), .match_o(match2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_lut();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pulse start on one instance and follow the sweep to the cycle after done
    task automatic run_sweep(input bit which, output int nbusy, output int ndone,
                             output bit tmo, output bit overlap, output bit xbad);
        logic       b, d;
        logic [6:0] x;
        nbusy = 0; ndone = 0; tmo = 1'b1; overlap = 1'b0; xbad = 1'b0;
        if (which) start2 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            b = which ? busy2 : busy0;
            d = which ? done2 : done0;
            x = which ? x2 : x0;
            if (b && d) overlap = 1'b1;
            if (b) begin
                if (x !== ((nbusy < 128) ? 7'(nbusy) : 7'd127)) xbad = 1'b1;
                nbusy++;
            end
            if (d) begin
                ndone++;
                tmo = 1'b0;
            end else if (ndone > 0) begin
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
        lut0 = '0; lut2 = '0;
        repeat (3) step();
        n_cmp++; if (x0 !== 7'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", x0); end
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy0, done0); end
        n_cmp++; if (tt0 !== '0) begin n_bad++; $display("FAIL reset_tt: got %h want 0", tt0); end
        n_cmp++; if (ones0 !== 8'd0 || match0 !== 1'b0) begin n_bad++; $display("FAIL reset_ones_match: got %0d/%b want 0/0", ones0, match0); end
        n_cmp++; if ({x2, busy2, done2, tt2, ones2, match2} !== '0) begin n_bad++; $display("FAIL reset_lat2: got nonzero outputs want all 0"); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_const_zero();
        int nb, nd; bit tmo, ov, xb;
        lut0 = '0;
        run_sweep(1'b0, nb, nd, tmo, ov, xb);
        n_cmp++; if (nb != 128) begin n_bad++; $display("FAIL zero_busy_len: got %0d want 128", nb); end
        n_cmp++; if (nd != 1 || tmo) begin n_bad++; $display("FAIL zero_done_pulse: got %0d (timeout %b) want 1", nd, tmo); end
        n_cmp++; if (ov || xb) begin n_bad++; $display("FAIL zero_seq: got overlap %b xseq_err %b want 0 0", ov, xb); end
        n_cmp++; if (tt0 !== '0 || ones0 !== 8'd0 || match0 !== 1'b0) begin n_bad++; $display("FAIL zero_result: got %h/%0d/%b want 0/0/0", tt0, ones0, match0); end
    endtask

    task automatic test_x0();
        int nb, nd; bit tmo, ov, xb;
        for (int i = 0; i < 128; i++) lut0[i] = i[0];
        run_sweep(1'b0, nb, nd, tmo, ov, xb);
        n_cmp++; if (tt0 !== 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA) begin n_bad++; $display("FAIL x0_tt: got %h want aaaa..aaaa", tt0); end
        n_cmp++; if (ones0 !== 8'd64 || nd != 1) begin n_bad++; $display("FAIL x0_ones: got %0d (done %0d) want 64 (1)", ones0, nd); end
    endtask

    task automatic test_expected();
        int nb, nd; bit tmo, ov, xb;
        int m, ref_ones;
        lut0 = EXP;
        ref_ones = $countones(EXP);
        run_sweep(1'b0, nb, nd, tmo, ov, xb);
        n_cmp++; if (tt0 !== EXP || match0 !== 1'b1) begin n_bad++; $display("FAIL exp_match: got %h/%b want %h/1", tt0, match0, EXP); end
        n_cmp++; if (int'(ones0) != ref_ones) begin n_bad++; $display("FAIL exp_ones: got %0d want %0d", ones0, ref_ones); end
        m = $urandom_range(0, 127);
        lut0 = EXP;
        lut0[m] = ~lut0[m];
        run_sweep(1'b0, nb, nd, tmo, ov, xb);
        n_cmp++; if (match0 !== 1'b0 || tt0 !== lut0) begin n_bad++; $display("FAIL flip_match: minterm %0d got %b want 0", m, match0); end
        n_cmp++; if (int'(ones0) != (EXP[m] ? ref_ones - 1 : ref_ones + 1)) begin n_bad++; $display("FAIL flip_ones: got %0d want %0d +/-1", ones0, ref_ones); end
    endtask

    task automatic test_random();
        int nb, nd; bit tmo, ov, xb;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin
                for (int i = 0; i < 128; i++) lut0[i] = ($countones(i) >= 4);
            end else begin
                lut0 = rand_lut();
            end
            run_sweep(1'b0, nb, nd, tmo, ov, xb);
            n_cmp++; if (tt0 !== lut0) begin n_bad++; $display("FAIL rand%0d_tt: got %h want %h", it, tt0, lut0); end
            n_cmp++; if (int'(ones0) != $countones(lut0) || match0 !== (lut0 == EXP)) begin n_bad++; $display("FAIL rand%0d_ones_match: got %0d/%b want %0d/%b", it, ones0, match0, $countones(lut0), (lut0 == EXP)); end
            n_cmp++; if (nb != 128 || nd != 1 || ov || xb) begin n_bad++; $display("FAIL rand%0d_timing: got busy %0d done %0d ov %b xerr %b want 128 1 0 0", it, nb, nd, ov, xb); end
        end
    endtask

    task automatic test_latency();
        int nb, nd; bit tmo, ov, xb;
        for (int i = 0; i < 128; i++) lut2[i] = i[0] & i[1];
        run_sweep(1'b1, nb, nd, tmo, ov, xb);
        n_cmp++; if (nb != 130 || nd != 1 || tmo || ov || xb) begin n_bad++; $display("FAIL lat2_timing: got busy %0d done %0d tmo %b ov %b xerr %b want 130 1 0 0 0", nb, nd, tmo, ov, xb); end
        n_cmp++; if (tt2 !== 128'h8888_8888_8888_8888_8888_8888_8888_8888) begin n_bad++; $display("FAIL lat2_tt: got %h want 8888..8888", tt2); end
        n_cmp++; if (ones2 !== 8'd32 || match2 !== 1'b0) begin n_bad++; $display("FAIL lat2_ones: got %0d/%b want 32/0", ones2, match2); end
        for (int it = 0; it < 2; it++) begin
            lut2 = (it == 0) ? EXP : rand_lut();
            run_sweep(1'b1, nb, nd, tmo, ov, xb);
            n_cmp++; if (tt2 !== lut2 || int'(ones2) != $countones(lut2) || match2 !== (lut2 == EXP)) begin n_bad++; $display("FAIL lat2_rand%0d: got %h/%0d/%b want %h", it, tt2, ones2, match2, lut2); end
        end
    endtask

    task automatic test_reset_mid();
        int nb, nd; bit tmo, ov, xb;
        logic [127:0] mask;
        mask = '0;
        for (int i = 0; i < 50; i++) mask[i] = 1'b1;
        lut0 = rand_lut();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (50) step();
        n_cmp++; if (x0 !== 7'd50 || busy0 !== 1'b1 || int'(ones0) != $countones(lut0 & mask)) begin n_bad++; $display("FAIL mid_progress: got x %0d busy %b ones %0d want 50 1 %0d", x0, busy0, ones0, $countones(lut0 & mask)); end
        rst_n = 1'b0;
        step();
        n_cmp++; if ({x0, busy0, done0, tt0, ones0, match0} !== '0) begin n_bad++; $display("FAIL mid_reset: got x %0d busy %b done %b ones %0d tt %h want all 0", x0, busy0, done0, ones0, tt0); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got busy %b want 0", busy0); end
        run_sweep(1'b0, nb, nd, tmo, ov, xb);
        n_cmp++; if (nb != 128 || nd != 1 || tt0 !== lut0 || int'(ones0) != $countones(lut0)) begin n_bad++; $display("FAIL mid_resweep: got busy %0d done %0d tt %h want 128 1 %h", nb, nd, tt0, lut0); end
    endtask

    task automatic test_start_held();
        int nb, nd;
        bit seen;
        logic [127:0] first;
        lut0 = rand_lut();
        first = lut0;
        nb = 0; nd = 0; seen = 1'b0;
        start0 = 1'b1;
        step();
        for (int k = 0; k < 400 && !seen; k++) begin
            if (busy0) nb++;
            if (done0) begin
                nd++;
                seen = 1'b1;
            end
            step();
        end
        // start stayed high through the DONE cycle; drop it now, in IDLE
        start0 = 1'b0;
        n_cmp++; if (!seen || nb != 128 || nd != 1) begin n_bad++; $display("FAIL held_one_sweep: got busy %0d done %0d want 128 1", nb, nd); end
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== first || int'(ones0) != $countones(first)) begin n_bad++; $display("FAIL held_idle_hold: got busy %b done %b tt %h want 0 0 %h", busy0, done0, tt0, first); end
        lut0 = rand_lut();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n_cmp++; if (busy0 !== 1'b1 || tt0 !== '0 || ones0 !== 8'd0 || match0 !== 1'b0) begin n_bad++; $display("FAIL restart_clear: got busy %b tt %h ones %0d match %b want 1 0 0 0", busy0, tt0, ones0, match0); end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done0) seen = 1'b1;
            else step();
        end
        n_cmp++; if (!seen || tt0 !== lut0) begin n_bad++; $display("FAIL restart_result: got done %b tt %h want 1 %h", seen, tt0, lut0); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_const_zero();
        test_x0();
        test_expected();
        test_random();
        test_latency();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tt_sweep_capture
`default_nettype wire
